// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer and its PWM input-capture companion.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Terminal prescaler count for a tick every 2^sel clocks.
    function automatic logic [6:0] prescale_term(input logic [2:0] sel);
        logic [7:0] w_full;
        w_full = (8'd1 << sel) - 8'd1;
        return w_full[6:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every 2^i_sel clocks.
module tick_prescaler
    import timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic [2:0] i_sel,
    output logic       o_tick
);

    logic [6:0] r_count;
    logic [6:0] w_term;

    assign w_term = prescale_term(i_sel);
    assign o_tick = (r_count == w_term);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 7'd1;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Input-capture unit: measures period and high time of an asynchronous PWM input
// in prescaled ticks, with a capture strobe, sticky interrupt and sticky timeout.
module pwm_capture
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_pwm_in,
    input  logic [3:0]       i_clk_control,
    input  logic             i_int_clr,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high_time,
    output logic             o_capture_valid,
    output logic             o_capture_interrupt,
    output logic             o_timeout,
    output logic             o_busy
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_e                 r_state;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_hi_lat;
    logic [WIDTH-1:0]       r_period;
    logic [WIDTH-1:0]       r_high_time;
    logic                   r_valid;
    logic                   r_irq;
    logic                   r_timeout;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_tick;
    logic                   w_presc_clear;
    logic [WIDTH:0]         w_cnt_next;
    logic                   w_overflow;

    // Synchroniser and edge detector run in every state so enabling on a high input is quiet.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;

    assign w_presc_clear = (r_state == IDLE) || (r_state == ARM) || ((r_state == LOW) && w_rise);

    tick_prescaler u_prescaler (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .i_clear (w_presc_clear),
        .i_sel   (i_clk_control[2:0]),
        .o_tick  (w_tick)
    );

    // One extra bit so a tick on a full counter shows up as overflow, even with an edge.
    assign w_cnt_next = {1'b0, r_cnt} + {{WIDTH{1'b0}}, w_tick};
    assign w_overflow = w_cnt_next[WIDTH];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hi_lat    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_irq       <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_int_clr) begin
                r_irq     <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (!i_enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: r_state <= ARM;
                    ARM: begin
                        if (w_rise) begin
                            r_cnt   <= '0;
                            r_state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (w_overflow) begin
                            r_timeout <= 1'b1;
                            r_state   <= ARM;
                        end else if (w_fall) begin
                            r_hi_lat <= w_cnt_next[WIDTH-1:0];
                            r_cnt    <= w_cnt_next[WIDTH-1:0];
                            r_state  <= LOW;
                        end else begin
                            r_cnt <= w_cnt_next[WIDTH-1:0];
                        end
                    end
                    LOW: begin
                        if (w_overflow) begin
                            r_timeout <= 1'b1;
                            r_state   <= ARM;
                        end else if (w_rise) begin
                            r_period    <= w_cnt_next[WIDTH-1:0];
                            r_high_time <= r_hi_lat;
                            r_valid     <= 1'b1;
                            r_irq       <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= HIGH;
                        end else begin
                            r_cnt <= w_cnt_next[WIDTH-1:0];
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_period            = r_period;
    assign o_high_time         = r_high_time;
    assign o_capture_valid     = r_valid;
    assign o_capture_interrupt = r_irq;
    assign o_timeout           = r_timeout;
    assign o_busy              = (r_state == HIGH) || (r_state == LOW);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: hand-computed capture values and strobe timing.
module tb_pwm_capture;

    logic       i_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_pwm_in = 1'b0;
    logic [3:0] i_clk_control = 4'd0;
    logic       i_int_clr = 1'b0;
    logic [7:0] o_period;
    logic [7:0] o_high_time;
    logic       o_capture_valid;
    logic       o_capture_interrupt;
    logic       o_timeout;
    logic       o_busy;

    int checks = 0;
    int failures = 0;

    pwm_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk               (i_clk),
        .rst_n               (rst_n),
        .i_enable            (i_enable),
        .i_pwm_in            (i_pwm_in),
        .i_clk_control       (i_clk_control),
        .i_int_clr           (i_int_clr),
        .o_period            (o_period),
        .o_high_time         (o_high_time),
        .o_capture_valid     (o_capture_valid),
        .o_capture_interrupt (o_capture_interrupt),
        .o_timeout           (o_timeout),
        .o_busy              (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Return to ARM with a settled low input.
    task automatic rearm();
        i_enable  = 1'b0;
        i_pwm_in  = 1'b0;
        i_int_clr = 1'b0;
        repeat (5) step();
        i_enable = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_pwm_in = k[0];
            step();
        end
        obs = {o_period, o_high_time, o_capture_valid, o_capture_interrupt, o_timeout, o_busy};
        checks++;
        if (obs !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        i_pwm_in = 1'b0;
        step();
        rst_n    = 1'b1;
        i_enable = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_basic();
        logic exp_v;
        int   strobes = 0;
        for (int k = 0; k < 60; k++) begin
            i_pwm_in = ((k % 8) < 3);
            step();
            exp_v = (k >= 10) && (((k - 2) % 8) == 0);
            checks++;
            if (o_capture_valid !== exp_v) begin
                failures++;
                $display("FAIL basic_valid k=%0d: got %b expected %b", k, o_capture_valid, exp_v);
            end
            if (exp_v) begin
                strobes++;
                checks++;
                if (o_period !== 8'd8 || o_high_time !== 8'd3) begin
                    failures++;
                    $display("FAIL basic_values: got period=%0d high=%0d expected 8/3",
                             o_period, o_high_time);
                end
            end
        end
        checks++;
        if (strobes != 7) begin
            failures++;
            $display("FAIL basic_strobe_count: got %0d expected 7", strobes);
        end
    endtask

    task automatic test_prescale();
        logic exp_v;
        i_clk_control = 4'd3;
        rearm();
        for (int k = 0; k < 400; k++) begin
            i_pwm_in = ((k % 128) < 40);
            if (k == 200) i_clk_control = 4'b1011;
            step();
            exp_v = (k >= 130) && (((k - 2) % 128) == 0);
            checks++;
            if (o_capture_valid !== exp_v) begin
                failures++;
                $display("FAIL presc_valid k=%0d: got %b expected %b", k, o_capture_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 8'd16 || o_high_time !== 8'd5) begin
                    failures++;
                    $display("FAIL presc_values k=%0d: got period=%0d high=%0d expected 16/5",
                             k, o_period, o_high_time);
                end
            end
        end
    endtask

    task automatic test_timeout();
        i_clk_control = 4'd0;
        rearm();
        for (int k = 0; k < 300; k++) begin
            i_pwm_in = 1'b1;
            step();
            checks++;
            if (o_capture_valid !== 1'b0) begin
                failures++;
                $display("FAIL timeout_no_strobe k=%0d: got 1 expected 0", k);
            end
            if (k == 257) begin
                checks++;
                if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL timeout_early: got timeout=%b busy=%b expected 0/1",
                             o_timeout, o_busy);
                end
            end
            if (k == 258) begin
                checks++;
                if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_set: got timeout=%b busy=%b expected 1/0",
                             o_timeout, o_busy);
                end
            end
        end
        checks++;
        if (o_period !== 8'd16 || o_high_time !== 8'd5) begin
            failures++;
            $display("FAIL timeout_hold: got period=%0d high=%0d expected 16/5",
                     o_period, o_high_time);
        end
    endtask

    task automatic test_int_clr();
        i_int_clr = 1'b1;
        step();
        i_int_clr = 1'b0;
        checks++;
        if (o_timeout !== 1'b0 || o_capture_interrupt !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: got timeout=%b irq=%b expected 0/0",
                     o_timeout, o_capture_interrupt);
        end
        i_pwm_in = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 14; k++) begin
            i_pwm_in  = (k == 4) || (k == 5) || (k >= 8);
            i_int_clr = (k == 10) || (k == 12);
            step();
            if (k == 10) begin
                checks++;
                if (o_capture_valid !== 1'b1 || o_capture_interrupt !== 1'b1 ||
                    o_period !== 8'd4 || o_high_time !== 8'd2) begin
                    failures++;
                    $display("FAIL clr_set_wins: got v=%b irq=%b p=%0d h=%0d expected 1/1/4/2",
                             o_capture_valid, o_capture_interrupt, o_period, o_high_time);
                end
            end
            if (k == 12) begin
                checks++;
                if (o_capture_interrupt !== 1'b0) begin
                    failures++;
                    $display("FAIL clr_irq: got %b expected 0", o_capture_interrupt);
                end
            end
        end
        i_int_clr = 1'b0;
    endtask

    task automatic test_disable();
        logic exp_v;
        rearm();
        for (int k = 0; k < 41; k++) begin
            if (k == 0)  i_pwm_in = 1'b1;
            if (k == 3)  i_pwm_in = 1'b0;
            if (k == 7)  i_enable = 1'b0;
            if (k == 8)  i_pwm_in = 1'b1;
            if (k == 14) i_enable = 1'b1;
            if (k == 20) i_pwm_in = 1'b0;
            if (k == 25) i_pwm_in = 1'b1;
            if (k == 28) i_pwm_in = 1'b0;
            if (k == 33) i_pwm_in = 1'b1;
            step();
            exp_v = (k == 35);
            checks++;
            if (o_capture_valid !== exp_v) begin
                failures++;
                $display("FAIL disable_valid k=%0d: got %b expected %b", k, o_capture_valid, exp_v);
            end
            if (k == 6 || k == 7) begin
                checks++;
                if (o_busy !== (k == 6)) begin
                    failures++;
                    $display("FAIL disable_busy k=%0d: got %b expected %b", k, o_busy, k == 6);
                end
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 8'd8 || o_high_time !== 8'd3) begin
                    failures++;
                    $display("FAIL disable_values: got period=%0d high=%0d expected 8/3",
                             o_period, o_high_time);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] obs;
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_busy: got %b expected 1", o_busy);
        end
        @(posedge i_clk);
        #3 rst_n = 1'b0;
        #1;
        obs = {o_period, o_high_time, o_capture_valid, o_capture_interrupt, o_timeout, o_busy};
        checks++;
        if (obs !== 20'd0) begin
            failures++;
            $display("FAIL areset_outputs: got %h expected 0", obs);
        end
        i_pwm_in = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_long_duty();
        logic exp_v;
        i_clk_control = 4'd0;
        rearm();
        for (int k = 0; k < 450; k++) begin
            i_pwm_in = ((k % 220) < 120);
            step();
            exp_v = (k == 222) || (k == 442);
            checks++;
            if (o_capture_valid !== exp_v) begin
                failures++;
                $display("FAIL duty_valid k=%0d: got %b expected %b", k, o_capture_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 8'd220 || o_high_time !== 8'd120) begin
                    failures++;
                    $display("FAIL duty_values: got period=%0d high=%0d expected 220/120",
                             o_period, o_high_time);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_timeout();
        test_int_clr();
        test_disable();
        test_async_reset();
        test_long_duty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
